reindeer_mm_periph: RTL and testbench
=====================================

REINDEER_MM_PERIPH -- requirements
Module: reindeer_mm_periph

Interface
REQ-001 Parameter ADDR_BITS, default 8: width of the word address bus.
REQ-002 Parameter TX_FIFO_DEPTH, default 8: UART TX FIFO depth, power of 2 in the range 2..64.
REQ-003 Parameter NUM_TIMERS, default 2: number of countdown timers, range 1..4.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; the ports are clk and sync_reset, and there is no other reset port.
REQ-005 Ports, as name / direction / width / meaning:
- clk, in, 1: clock.
- sync_reset, in, 1: synchronous active-high reset.
- data_read_enable, in, 1: read strobe.
- data_write_enable, in, 1: write strobe.
- data_rw_addr, in, ADDR_BITS: word address.
- data_write_word, in, 32: write data.
- start_TX, out, 1: one-cycle pulse that starts a UART byte.
- tx_data, out, 8: byte for the UART, valid while start_TX=1.
- tx_active, in, 1: UART busy.
- enable_out, out, 1: read/write acknowledge.
- word_out, out, 32: read data.
- timer_triggered, out, 1: OR of all timer pending bits.

Function
REQ-006 Register map (word addresses):
- 0 TX_DATA: write pushes data_write_word[7:0]; read returns 0.
- 1 TX_STATUS: bit31 full, bit30 tx_active, bit29 empty, bit28 overflow, [6:0] FIFO level; any write clears overflow.
- 2 IRQ_PEND: bit k = timer k pending; write 1 clears that bit.
- 4+2k TMR_LOAD(k): write loads count and reload; read returns current count.
- 5+2k TMR_CTRL(k): bit0 enable, bit1 periodic.
REQ-007 enable_out SHALL be high exactly one cycle after any cycle with data_read_enable or data_write_enable.
REQ-008 word_out SHALL be registered, valid in the enable_out cycle, and 0 for unmapped addresses and for write-only cycles.
REQ-009 A push to a full FIFO SHALL be dropped and SHALL set overflow; fullness is judged before any same-cycle pop.
REQ-010 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the level unchanged; pointers wrap modulo TX_FIFO_DEPTH.
REQ-011 TX FSM states and transitions:
- IDLE -> ISSUE when FIFO not empty and tx_active=0.
- ISSUE: start_TX=1 for exactly one cycle, head byte popped onto tx_data -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE when tx_active=1; -> IDLE after 2 cycles without tx_active (timeout).
- WAIT_DONE -> IDLE when tx_active=0.
REQ-012 start_TX SHALL never be asserted on two consecutive cycles.
REQ-013 Timer k, each cycle with enable=1:
- count>1: decrement.
- count==1: set pending[k]; count becomes reload if periodic=1 and reload!=0, else 0.
- count==0: hold, no event.
REQ-014 A TMR_LOAD write SHALL take priority over decrement in the same cycle.
REQ-015 A pending set SHALL win over a same-cycle write-1-to-clear of that bit.
REQ-016 timer_triggered SHALL be combinational OR of pending bits.
REQ-017 Overflow set SHALL win over a same-cycle TX_STATUS write.

Reset
REQ-018 On sync_reset=1 at a clk edge, all of the following SHALL become 0:
- enable_out, word_out, start_TX, tx_data.
- FIFO pointers, level and overflow.
- pending bits, counts, reloads and CTRL.
- FSM state (IDLE).
REQ-019 Reset SHALL take effect mid-transfer; FIFO contents are discarded, and the FSM SHALL ignore tx_active until it returns to IDLE.

Configuration
REQ-020 Macro REINDEER_MM_TIMER_PERIODIC_EN:
- Defined: periodic reload per REQ-013.
- Undefined: CTRL bit1 not stored and reads 0; all timers are one-shot.

Verification
REQ-021 Push 0x41,0x42,0x43 with the UART model busy 10 cycles per byte -> three single-cycle start_TX pulses with tx_data 0x41,0x42,0x43 in order, no overlap with tx_active.
REQ-022 Hold tx_active=1 and push TX_FIFO_DEPTH+1 bytes -> TX_STATUS read returns full=1, overflow=1, level=TX_FIFO_DEPTH; a write to TX_STATUS clears overflow.
REQ-023 TMR_LOAD(0)=5, CTRL=0x1 -> pending[0] and timer_triggered high 5 cycles after enable; count reads 0; writing IRQ_PEND=0x1 clears it.
REQ-024 With REINDEER_MM_TIMER_PERIODIC_EN: LOAD=3, CTRL=0x3 -> pending set every 3 cycles; clear issued on an expiry cycle leaves pending=1.
REQ-025 Assert sync_reset during WAIT_DONE with 4 bytes queued -> next cycle: empty=1, level=0, no start_TX until a new push.
REQ-026 Read address 0x3F -> enable_out=1 next cycle with word_out=0.

Source files
------------

// File: rtl/reindeer_mm_periph.sv
// reindeer_mm_periph: memory-mapped peripheral block with a UART TX FIFO,
// a TX issue state machine and NUM_TIMERS countdown timers with a pending
// interrupt register.
//
// Optional feature macro: REINDEER_MM_TIMER_PERIODIC_EN
//   defined   -> timers support periodic reload (CTRL bit1)
//   undefined -> CTRL bit1 is not stored, all timers are one-shot

// One countdown timer lane: count/reload/ctrl state and the expiry event.
module reindeer_mm_timer (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        load_wr,
  input  logic        ctrl_wr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [1:0]  ctrl,
  output logic        expire
);
  logic enable;
`ifdef REINDEER_MM_TIMER_PERIODIC_EN
  logic        periodic;
  logic [31:0] reload;
`endif

  // Expiry fires on the cycle an enabled count of one is consumed; a load
  // in the same cycle overrides the whole countdown step.
  always_comb begin
    expire = enable && (count == 32'd1) && !load_wr;
  end

  // Count: load beats decrement, zero holds.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      count <= '0;
    end else if (load_wr) begin
      count <= wdata;
    end else if (enable && (count > 32'd1)) begin
      count <= count - 32'd1;
    end else if (expire) begin
`ifdef REINDEER_MM_TIMER_PERIODIC_EN
      count <= (periodic && (reload != 32'd0)) ? reload : 32'd0;
`else
      count <= 32'd0;
`endif
    end
  end

  // Enable bit of CTRL.
  always_ff @(posedge clk) begin
    if (sync_reset) enable <= 1'b0;
    else if (ctrl_wr) enable <= wdata[0];
  end

`ifdef REINDEER_MM_TIMER_PERIODIC_EN
  // Periodic bit and reload value, only kept when reload is supported.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      periodic <= 1'b0;
      reload   <= '0;
    end else begin
      if (ctrl_wr) periodic <= wdata[1];
      if (load_wr) reload   <= wdata;
    end
  end

  // CTRL readback.
  always_comb begin
    ctrl = {periodic, enable};
  end
`else
  // CTRL readback; periodic bit reads as zero.
  always_comb begin
    ctrl = {1'b0, enable};
  end
`endif

endmodule

module reindeer_mm_periph #(
  parameter int ADDR_BITS     = 8,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int NUM_TIMERS    = 2
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 data_read_enable,
  input  logic                 data_write_enable,
  input  logic [ADDR_BITS-1:0] data_rw_addr,
  input  logic [31:0]          data_write_word,
  output logic                 start_TX,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  output logic                 enable_out,
  output logic [31:0]          word_out,
  output logic                 timer_triggered
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [ADDR_BITS-1:0] A_TX_DATA   = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] A_TX_STATUS = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_IRQ_PEND  = ADDR_BITS'(2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------- decode
  logic push, push_ok, pop, sts_wr, pend_wr;
  logic fifo_full, fifo_empty;

  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;

  tx_state_t state, state_nxt;
  logic      wait_cnt;
  logic      load_tx;

  logic [NUM_TIMERS-1:0][31:0] tmr_count;
  logic [NUM_TIMERS-1:0][1:0]  tmr_ctrl;
  logic [NUM_TIMERS-1:0]       tmr_load_wr, tmr_ctrl_wr, tmr_expire;
  logic [NUM_TIMERS-1:0]       pending, pend_clr;

  logic [31:0] rdata;

  // Bus write decode and FIFO flags; fullness is taken before any pop.
  always_comb begin
    push       = data_write_enable && (data_rw_addr == A_TX_DATA);
    sts_wr     = data_write_enable && (data_rw_addr == A_TX_STATUS);
    pend_wr    = data_write_enable && (data_rw_addr == A_IRQ_PEND);
    fifo_full  = (level == LVL_W'(TX_FIFO_DEPTH));
    fifo_empty = (level == '0);
    push_ok    = push && !fifo_full;
    pend_clr   = pend_wr ? data_write_word[NUM_TIMERS-1:0] : '0;
  end

  // ------------------------------------------------------------- TX FIFO
  // FIFO storage; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_write_word[7:0];
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop keeps level.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a dropped push beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (sync_reset)             overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
    else if (sts_wr)            overflow <= 1'b0;
  end

  // -------------------------------------------------------------- TX FSM
  // State register plus the two-cycle busy-wait timeout counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state    <= IDLE;
      wait_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT_BUSY);
    end
  end

  // Next state: issue when data waits and the UART is free, then wait for
  // the UART to pick it up (or give up after two cycles) and finish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!fifo_empty && !tx_active) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_active)     state_nxt = WAIT_DONE;
        else if (wait_cnt) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_active) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM outputs: one-cycle start pulse and FIFO pop in ISSUE, head byte
  // captured on the way into ISSUE so tx_data is valid with the pulse.
  always_comb begin
    start_TX = (state == ISSUE);
    pop      = (state == ISSUE);
    load_tx  = (state == IDLE) && (state_nxt == ISSUE);
  end

  // Byte presented to the UART.
  always_ff @(posedge clk) begin
    if (sync_reset)   tx_data <= 8'd0;
    else if (load_tx) tx_data <= fifo_mem[rd_ptr];
  end

  // -------------------------------------------------------------- timers
  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
    assign tmr_load_wr[k] = data_write_enable && (data_rw_addr == ADDR_BITS'(4 + 2 * k));
    assign tmr_ctrl_wr[k] = data_write_enable && (data_rw_addr == ADDR_BITS'(5 + 2 * k));

    reindeer_mm_timer u_tmr (
      .clk        (clk),
      .sync_reset (sync_reset),
      .load_wr    (tmr_load_wr[k]),
      .ctrl_wr    (tmr_ctrl_wr[k]),
      .wdata      (data_write_word),
      .count      (tmr_count[k]),
      .ctrl       (tmr_ctrl[k]),
      .expire     (tmr_expire[k])
    );
  end

  // Pending bits: set beats write-1-to-clear.
  always_ff @(posedge clk) begin
    if (sync_reset) pending <= '0;
    else            pending <= (pending & ~pend_clr) | tmr_expire;
  end

  // Interrupt line.
  always_comb begin
    timer_triggered = |pending;
  end

  // ------------------------------------------------------------ bus read
  // Read mux; unmapped addresses and TX_DATA return zero.
  always_comb begin
    rdata = '0;
    if (data_rw_addr == A_TX_STATUS)
      rdata = {fifo_full, tx_active, fifo_empty, overflow, 21'd0, 7'(level)};
    else if (data_rw_addr == A_IRQ_PEND)
      rdata[NUM_TIMERS-1:0] = pending;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (data_rw_addr == ADDR_BITS'(4 + 2 * k)) rdata = tmr_count[k];
      if (data_rw_addr == ADDR_BITS'(5 + 2 * k)) rdata = {30'd0, tmr_ctrl[k]};
    end
  end

  // Registered acknowledge and read data; write-only cycles return zero.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      enable_out <= 1'b0;
      word_out   <= '0;
    end else begin
      enable_out <= data_read_enable || data_write_enable;
      word_out   <= data_read_enable ? rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_reindeer_mm_periph.sv
// Directed bench for reindeer_mm_periph: TX FIFO/FSM with a UART model,
// overflow, timers, pending clear races, mid-transfer reset, unmapped reads.
module tb_reindeer_mm_periph;
  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        start_TX;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        enable_out;
  logic [31:0] word_out;
  logic        timer_triggered;

  int n_checks = 0;
  int n_fail   = 0;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] tx_log [$];
  int         consec_err = 0, overlap_err = 0;
  logic       prev_start = 1'b0;

  reindeer_mm_periph #(.ADDR_BITS(8), .TX_FIFO_DEPTH(8), .NUM_TIMERS(2)) dut (
    .clk               (clk),
    .sync_reset        (sync_reset),
    .data_read_enable  (rd),
    .data_write_enable (wr),
    .data_rw_addr      (addr),
    .data_write_word   (wdata),
    .start_TX          (start_TX),
    .tx_data           (tx_data),
    .tx_active         (tx_active),
    .enable_out        (enable_out),
    .word_out          (word_out),
    .timer_triggered   (timer_triggered)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each start pulse
  assign tx_active = hold_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    if (start_TX) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // start pulse monitor
  always @(negedge clk) begin
    if (start_TX) begin
      tx_log.push_back(tx_data);
      if (prev_start) consec_err++;
      if (tx_active) overlap_err++;
    end
    prev_start = start_TX;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = word_out;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    sync_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sync_reset = 1'b0;
    n_checks++; if (enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_enable_out: got %b expected 0", enable_out); end
    n_checks++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word_out: got %h expected 0", word_out); end
    n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL reset_start_tx: got %b expected 0", start_TX); end
    n_checks++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL reset_timer_triggered: got %b expected 0", timer_triggered); end
    bus_read(8'd1, d);
    n_checks++; if (enable_out !== 1'b1) begin n_fail++; $display("FAIL reset_read_ack: got %b expected 1", enable_out); end
    n_checks++; if (d !== 32'h2000_0000) begin n_fail++; $display("FAIL reset_status: got %h expected 20000000", d); end
    bus_read(8'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tmr_count: got %h expected 0", d); end
  endtask

  task automatic test_uart_sequence;
    logic [31:0] d;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    tx_log.delete();
    bus_write(8'd0, 32'h41);
    bus_write(8'd0, 32'h42);
    bus_write(8'd0, 32'h43);
    for (int i = 0; i < 300 && tx_log.size() < 3; i++) @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (tx_log.size() !== 3) begin n_fail++; $display("FAIL uart_pulse_count: got %0d expected 3", tx_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < tx_log.size()) begin
        n_checks++; if (tx_log[i] !== exp_b[i]) begin n_fail++; $display("FAIL uart_byte%0d: got %h expected %h", i, tx_log[i], exp_b[i]); end
      end
    end
    n_checks++; if (consec_err !== 0) begin n_fail++; $display("FAIL uart_consecutive_start: got %0d expected 0", consec_err); end
    n_checks++; if (overlap_err !== 0) begin n_fail++; $display("FAIL uart_overlap_busy: got %0d expected 0", overlap_err); end
    bus_read(8'd1, d);
    n_checks++; if (d !== 32'h2000_0000) begin n_fail++; $display("FAIL uart_status_drained: got %h expected 20000000", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    hold_busy = 1'b1;
    tx_log.delete();
    for (int i = 0; i < 9; i++) bus_write(8'd0, 32'h10 + 32'(i));
    bus_read(8'd1, d);
    n_checks++; if (d !== 32'hD000_0008) begin n_fail++; $display("FAIL ovf_status_full: got %h expected d0000008", d); end
    bus_write(8'd1, 32'h0);
    n_checks++; if (enable_out !== 1'b1) begin n_fail++; $display("FAIL ovf_write_ack: got %b expected 1", enable_out); end
    n_checks++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL ovf_write_word_out: got %h expected 0", word_out); end
    bus_read(8'd1, d);
    n_checks++; if (d !== 32'hC000_0008) begin n_fail++; $display("FAIL ovf_cleared: got %h expected c0000008", d); end
    hold_busy = 1'b0;
    for (int i = 0; i < 400 && tx_log.size() < 8; i++) @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (tx_log.size() !== 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 8", tx_log.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < tx_log.size()) begin
        n_checks++; if (tx_log[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL ovf_drain_byte%0d: got %h expected %h", i, tx_log[i], 8'(8'h10 + i)); end
      end
    end
    bus_read(8'd1, d);
    n_checks++; if (d !== 32'h2000_0000) begin n_fail++; $display("FAIL ovf_status_after_drain: got %h expected 20000000", d); end
  endtask

  task automatic test_timer_oneshot;
    logic [31:0] d;
    bus_write(8'd4, 32'd5);
    bus_write(8'd5, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL tmr_early: got %b expected 0", timer_triggered); end
    @(posedge clk); #1;
    n_checks++; if (timer_triggered !== 1'b1) begin n_fail++; $display("FAIL tmr_fire: got %b expected 1", timer_triggered); end
    bus_read(8'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tmr_count_zero: got %h expected 0", d); end
    bus_read(8'd2, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL tmr_pend_read: got %h expected 1", d); end
    bus_write(8'd2, 32'h1);
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL tmr_clear: got %b expected 0", timer_triggered); end
    bus_read(8'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tmr_pend_after_clear: got %h expected 0", d); end
    bus_write(8'd5, 32'h0);
  endtask

  task automatic test_load_priority;
    logic [31:0] d;
    bus_write(8'd6, 32'd3);
    bus_write(8'd7, 32'h1);
    bus_write(8'd6, 32'd10);
    bus_read(8'd6, d);
    n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL load_priority: got %0d expected 10", d); end
    bus_write(8'd7, 32'h0);
    bus_read(8'd7, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL tmr1_ctrl_off: got %h expected 0", d); end
  endtask

  task automatic test_pend_clear_race;
    logic [31:0] d;
    bus_write(8'd4, 32'd2);
    bus_write(8'd5, 32'h1);
    @(posedge clk); #1;
    bus_write(8'd2, 32'h1);
    n_checks++; if (timer_triggered !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b expected 1", timer_triggered); end
    bus_read(8'd2, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL race_pend_read: got %h expected 1", d); end
    bus_write(8'd2, 32'h1);
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL race_clear_after: got %b expected 0", timer_triggered); end
    bus_write(8'd5, 32'h0);
  endtask

`ifdef REINDEER_MM_TIMER_PERIODIC_EN
  task automatic test_timer_mode;
    logic [31:0] d;
    bus_write(8'd4, 32'd3);
    bus_write(8'd5, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL per_before_first: got %b expected 0", timer_triggered); end
    @(posedge clk); #1;
    n_checks++; if (timer_triggered !== 1'b1) begin n_fail++; $display("FAIL per_first_fire: got %b expected 1", timer_triggered); end
    bus_write(8'd2, 32'h1);
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL per_cleared: got %b expected 0", timer_triggered); end
    @(posedge clk); #1;
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL per_between: got %b expected 0", timer_triggered); end
    bus_write(8'd2, 32'h1);
    n_checks++; if (timer_triggered !== 1'b1) begin n_fail++; $display("FAIL per_clear_on_expiry: got %b expected 1", timer_triggered); end
    bus_read(8'd5, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL per_ctrl_read: got %h expected 3", d); end
    bus_write(8'd5, 32'h0);
    bus_write(8'd4, 32'h0);
    bus_write(8'd2, 32'h3);
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL per_final_clear: got %b expected 0", timer_triggered); end
  endtask
`else
  task automatic test_timer_mode;
    logic [31:0] d;
    bus_write(8'd4, 32'd2);
    bus_write(8'd5, 32'h3);
    bus_read(8'd5, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL oneshot_ctrl_read: got %h expected 1", d); end
    @(posedge clk); #1;
    n_checks++; if (timer_triggered !== 1'b1) begin n_fail++; $display("FAIL oneshot_fire: got %b expected 1", timer_triggered); end
    bus_read(8'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL oneshot_no_reload: got %h expected 0", d); end
    bus_write(8'd5, 32'h0);
    bus_write(8'd2, 32'h3);
    n_checks++; if (timer_triggered !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear: got %b expected 0", timer_triggered); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] d;
    int base;
    for (int i = 0; i < 5; i++) bus_write(8'd0, 32'h60 + 32'(i));
    bus_read(8'd1, d);
    n_checks++; if (d !== 32'h4000_0004) begin n_fail++; $display("FAIL mid_precondition: got %h expected 40000004", d); end
    sync_reset = 1'b1;
    @(posedge clk); #1;
    sync_reset = 1'b0;
    n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL mid_start_tx: got %b expected 0", start_TX); end
    n_checks++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL mid_tx_data: got %h expected 0", tx_data); end
    n_checks++; if (enable_out !== 1'b0) begin n_fail++; $display("FAIL mid_enable_out: got %b expected 0", enable_out); end
    bus_read(8'd1, d);
    n_checks++; if ((d & 32'hBFFF_FFFF) !== 32'h2000_0000) begin n_fail++; $display("FAIL mid_status_empty: got %h expected 20000000 (bit30 ignored)", d); end
    base = tx_log.size();
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (tx_log.size() !== base) begin n_fail++; $display("FAIL mid_no_start: got %0d expected %0d", tx_log.size(), base); end
    bus_write(8'd0, 32'h55);
    for (int i = 0; i < 200 && tx_log.size() < base + 1; i++) @(posedge clk);
    #1;
    n_checks++; if (tx_log.size() !== base + 1) begin n_fail++; $display("FAIL mid_new_push_count: got %0d expected %0d", tx_log.size(), base + 1); end
    else begin
      n_checks++; if (tx_log[base] !== 8'h55) begin n_fail++; $display("FAIL mid_new_push_byte: got %h expected 55", tx_log[base]); end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    bus_read(8'd1, d);
    bus_read(8'h3F, d);
    n_checks++; if (enable_out !== 1'b1) begin n_fail++; $display("FAIL unmapped_ack: got %b expected 1", enable_out); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_3f: got %h expected 0", d); end
    bus_read(8'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_3: got %h expected 0", d); end
    bus_read(8'd8, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_8: got %h expected 0", d); end
    bus_read(8'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back;
    bus_write(8'd1, 32'hFFFF_FFFF);
    n_checks++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL b2b_write_word_out: got %h expected 0", word_out); end
    @(posedge clk); #1;
    n_checks++; if (enable_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ack: got %b expected 0", enable_out); end
    n_checks++; if (consec_err !== 0) begin n_fail++; $display("FAIL b2b_consecutive_start: got %0d expected 0", consec_err); end
    n_checks++; if (overlap_err !== 0) begin n_fail++; $display("FAIL b2b_overlap_busy: got %0d expected 0", overlap_err); end
  endtask

  initial begin
    test_reset();
    test_uart_sequence();
    test_overflow();
    test_timer_oneshot();
    test_load_priority();
    test_pend_clear_race();
    test_timer_mode();
    test_reset_mid();
    test_unmapped();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
